norm_shift_ctrl: RTL and testbench

Iterative normalisation controller that sits directly upstream of the 25-bit left barrel shifter in the Nroot datapath. It takes a raw 25-bit mantissa and its biased exponent, and finds the left-shift amount that puts the leading one at bit 24. It then emits that amount as the 5-bit nshiftleft code (bit4=16, bit3=8, bit2=4, bit1=2, bit0=1), plus the normalised mantissa and the adjusted exponent. The search is a 5-step binary search, one step per cycle, and the shift is clamped so the exponent never drops below 1.

---
 rtl/norm_shift_ctrl.sv | 132 +++++++++++++
 tb/tb_norm_shift_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/norm_shift_ctrl.sv
// Iterative normalisation controller: finds the left shift that puts the leading
// one at bit MW-1 with a one-step-per-cycle binary search, clamped by the exponent.
module norm_shift_ctrl #(
  parameter int MW = 25,
  parameter int EW = 8,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [MW-1:0] mant_in,
  input  logic [EW-1:0] exp_in,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] nshiftleft,
  output logic [MW-1:0] mant_out,
  output logic [EW-1:0] exp_out,
  output logic          zero,
  output logic          denorm
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    S4   = 3'd2,
    S3   = 3'd3,
    S2   = 3'd4,
    S1   = 3'd5,
    S0   = 3'd6,
    DONE = 3'd7
  } state_t;

  localparam logic [EW-1:0] MAX_SHIFT = EW'((1 << SW) - 1);

  state_t        state, state_nxt;
  logic [MW-1:0] work;
  logic [EW-1:0] exp_r;
  logic [SW-1:0] acc;
  logic [SW-1:0] limit;
  logic          zflag;

  logic          accept;
  logic          step_en;
  logic [2:0]    step_k;
  logic [SW:0]   grp;
  logic [SW:0]   acc_sum;
  logic          grp_clear;
  logic          take;
  logic [EW-1:0] exp_m1;
  logic [SW-1:0] limit_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = S4;
      S4:      state_nxt = S3;
      S3:      state_nxt = S2;
      S2:      state_nxt = S1;
      S1:      state_nxt = S0;
      S0:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Step k tests the top 2^k bits of W; taking it sets acc[k].
  always_comb begin
    busy    = (state != IDLE);
    accept  = (state == IDLE) && start;
    step_en = 1'b0;
    step_k  = 3'd0;
    case (state)
      S4:      begin step_en = 1'b1; step_k = 3'd4; end
      S3:      begin step_en = 1'b1; step_k = 3'd3; end
      S2:      begin step_en = 1'b1; step_k = 3'd2; end
      S1:      begin step_en = 1'b1; step_k = 3'd1; end
      S0:      begin step_en = 1'b1; step_k = 3'd0; end
      default: begin step_en = 1'b0; step_k = 3'd0; end
    endcase
    grp       = (SW+1)'(1) << step_k;
    acc_sum   = {1'b0, acc} + grp;
    grp_clear = ((work >> (MW - int'(grp))) == '0);
    take      = step_en && grp_clear && (acc_sum <= {1'b0, limit}) && !zflag;
    exp_m1    = exp_in - EW'(1);
    if (exp_in == '0)          limit_nxt = '0;
    else if (exp_m1 > MAX_SHIFT) limit_nxt = MAX_SHIFT[SW-1:0];
    else                       limit_nxt = exp_m1[SW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work       <= '0;
      exp_r      <= '0;
      acc        <= '0;
      limit      <= '0;
      zflag      <= 1'b0;
      done       <= 1'b0;
      nshiftleft <= '0;
      mant_out   <= '0;
      exp_out    <= '0;
      zero       <= 1'b0;
      denorm     <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (accept) begin
        work  <= mant_in;
        exp_r <= exp_in;
        acc   <= '0;
        limit <= limit_nxt;
        zflag <= (mant_in == '0);
      end
      if (take) begin
        work <= work << grp;
        acc  <= acc | grp[SW-1:0];
      end
      if (state == DONE) begin
        nshiftleft <= acc;
        mant_out   <= work;
        exp_out    <= zflag ? '0 : exp_r - EW'(acc);
        zero       <= zflag;
        denorm     <= !zflag && !work[MW-1];
      end
    end
  end

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Randomised and directed bench for norm_shift_ctrl against an arithmetic
// leading-zero/clamp model with an expected-result queue.
module tb_norm_shift_ctrl;

  localparam int MW = 25;
  localparam int EW = 8;
  localparam int SW = 5;
  localparam int RW = SW + MW + EW + 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [MW-1:0] mant_in;
  logic [EW-1:0] exp_in;
  logic          busy;
  logic          done;
  logic [SW-1:0] nshiftleft;
  logic [MW-1:0] mant_out;
  logic [EW-1:0] exp_out;
  logic          zero;
  logic          denorm;

  logic [RW-1:0] exp_q[$];
  int n_vec;
  int n_bad;

  norm_shift_ctrl #(.MW(MW), .EW(EW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .mant_in(mant_in), .exp_in(exp_in),
    .busy(busy), .done(done), .nshiftleft(nshiftleft), .mant_out(mant_out),
    .exp_out(exp_out), .zero(zero), .denorm(denorm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: shift = min(leading zeros, exponent headroom), nothing for zero.
  function automatic logic [RW-1:0] model(input logic [MW-1:0] m, input logic [EW-1:0] e);
    int lz, lim, sh, ee;
    logic [MW-1:0] mo;
    logic z, dn;
    z  = (m == '0);
    lz = MW;
    for (int i = MW - 1; i >= 0; i--) begin
      if (m[i]) begin
        lz = MW - 1 - i;
        break;
      end
    end
    lim = (e == 0) ? 0 : ((int'(e) - 1 > 31) ? 31 : int'(e) - 1);
    sh  = z ? 0 : ((lz < lim) ? lz : lim);
    mo  = m << sh;
    ee  = z ? 0 : int'(e) - sh;
    dn  = !z && !mo[MW-1];
    return {SW'(sh), mo, EW'(ee), z, dn};
  endfunction

  task automatic check_outputs(input string tag);
    logic [RW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_nshiftleft"}, 32'(nshiftleft), 32'(e[RW-1 -: SW]));
      check({tag, "_mant_out"},   32'(mant_out),   32'(e[MW+EW+1 -: MW]));
      check({tag, "_exp_out"},    32'(exp_out),    32'(e[EW+1 -: EW]));
      check({tag, "_zero"},       32'(zero),       32'(e[1]));
      check({tag, "_denorm"},     32'(denorm),     32'(e[0]));
    end
  endtask

  // One transaction: optional extra start pulses mid-search and in the DONE cycle.
  task automatic run_op(input string tag, input logic [MW-1:0] m, input logic [EW-1:0] e,
                        input bit mid_start, input bit late_start);
    @(negedge clk);
    mant_in = m;
    exp_in  = e;
    start   = 1'b1;
    exp_q.push_back(model(m, e));
    @(posedge clk);
    #1;
    start   = 1'b0;
    mant_in = MW'($urandom);
    exp_in  = EW'($urandom);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      if (c == 2) start = mid_start;
      if (c == 3) start = 1'b0;
      if (c == 6) start = late_start;
      if (c < 7) begin
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_done_early"}, 32'(done), 32'd0);
      end else begin
        start = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check_outputs(tag);
      end
    end
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_nshiftleft"}, 32'(nshiftleft), 32'd0);
    check({tag, "_mant_out"},   32'(mant_out),   32'd0);
    check({tag, "_exp_out"},    32'(exp_out),    32'd0);
    check({tag, "_zero"},       32'(zero),       32'd0);
    check({tag, "_denorm"},     32'(denorm),     32'd0);
  endtask

  initial begin
    logic [MW-1:0] m;
    logic [EW-1:0] e;
    n_vec   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    start   = 1'b0;
    mant_in = '0;
    exp_in  = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);
    check_cleared("post_reset");

    run_op("lz24",      25'h0000001, 8'd100, 1'b0, 1'b0);
    run_op("norm",      25'h1000000, 8'd5,   1'b0, 1'b0);
    run_op("clamp",     25'h0001000, 8'd5,   1'b0, 1'b0);
    run_op("clamp_e0",  25'h0001000, 8'd0,   1'b0, 1'b0);
    run_op("zero_in",   25'h0000000, 8'd50,  1'b0, 1'b0);
    run_op("mid_start", 25'h0123456, 8'd60,  1'b1, 1'b0);
    run_op("late_start",25'h0000400, 8'd200, 1'b0, 1'b1);
    run_op("exp1",      25'h0000010, 8'd1,   1'b0, 1'b0);

    // Asynchronous reset while the search is in S2.
    @(negedge clk);
    mant_in = 25'h0000100;
    exp_in  = 8'd90;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_cleared("async_rst");
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 25'h0000003, 8'd30, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      m = MW'($urandom) >> $urandom_range(0, MW);
      case ($urandom_range(0, 3))
        0:       e = EW'($urandom_range(0, 3));
        1:       e = EW'($urandom_range(4, 30));
        default: e = EW'($urandom);
      endcase
      run_op("rand", m, e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
